// File: rtl/alu_pkg.sv
// Shared ALU constants: shift op codes, shift-unit state encodings and default widths.
package alu_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SHAMT_W = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_shift_unit_shift1.sv
// One mux row of the shifter: shifts A by a single bit, SLL with zero fill or SRA with sign fill.
module shift1_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    output logic [WIDTH-1:0] out,
    input  logic             op,
    input  logic [WIDTH-1:0] A
);

    assign out = (op == OP_SRA) ? {A[WIDTH-1], A[WIDTH-1:1]}
                                : {A[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/seq_shift_unit.sv
// Multicycle SLL/SRA unit: loads an operand on start, shifts one bit per clock, pulses o_done when finished.
module seq_shift_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic               i_op,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_result
);

    state_e             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_op;

    state_e             w_state_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [SHAMT_W-1:0] w_cnt_nxt;
    logic               w_op_nxt;
    logic [WIDTH-1:0]   w_shifted;

    shift1_stage #(
        .WIDTH (WIDTH)
    ) u_shift1 (
        .out (w_shifted),
        .op  (r_op),
        .A   (r_acc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= OP_SLL;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // Zero shift amount skips SHIFT so the counter never wraps below zero.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_start) begin
                    w_acc_nxt   = i_data;
                    w_cnt_nxt   = i_shamt;
                    w_op_nxt    = i_op;
                    w_state_nxt = (i_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_acc_nxt = w_shifted;
                w_cnt_nxt = r_cnt - SHAMT_W'(1);
                if (r_cnt == SHAMT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_ready  = (r_state == ST_IDLE);
    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_DONE);
    assign o_result = r_acc;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: cycle model of ready/busy/done/result plus directed literal checks.
module tb_seq_shift_unit;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               clock;
    logic               reset;
    logic               ctrl_start;
    logic               i_op;
    logic [WIDTH-1:0]   i_data;
    logic [SHAMT_W-1:0] i_shamt;
    logic               o_ready;
    logic               o_busy;
    logic               o_done;
    logic [WIDTH-1:0]   o_result;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    seq_shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_start (ctrl_start),
        .i_op       (i_op),
        .i_data     (i_data),
        .i_shamt    (i_shamt),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation is "edges left until ready" plus "bits shifted so far".
    bit               m_valid = 1'b0;
    int               m_to_ready = 0;
    int               m_k = 0;
    int               m_shamt = 0;
    logic             m_op = 1'b0;
    logic [WIDTH-1:0] m_data = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_valid    = 1'b1;
            m_to_ready = 0;
            m_k        = 0;
            m_shamt    = 0;
            m_op       = 1'b0;
            m_data     = '0;
        end else if (m_to_ready == 0) begin
            if (ctrl_start) begin
                m_data     = i_data;
                m_op       = i_op;
                m_shamt    = int'(i_shamt);
                m_k        = 0;
                m_to_ready = m_shamt + 1;
            end
        end else begin
            m_to_ready--;
            if (m_k < m_shamt) m_k++;
        end
    end

    function automatic logic [WIDTH-1:0] model_result();
        if (m_op) return WIDTH'($signed(m_data) >>> m_k);
        return m_data << m_k;
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            chk("ready", WIDTH'(o_ready), WIDTH'(m_to_ready == 0));
            chk("busy",  WIDTH'(o_busy),  WIDTH'(m_to_ready != 0));
            chk("done",  WIDTH'(o_done),  WIDTH'(m_to_ready == 1));
            chk("result", o_result, model_result());
        end
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch one op and wait for o_done with a bounded cycle budget; returns edges taken.
    task automatic run_op(input logic op, input logic [WIDTH-1:0] data, input logic [SHAMT_W-1:0] shamt,
                          output int lat);
        lat = 0;
        ctrl_start = 1'b1;
        i_op       = op;
        i_data     = data;
        i_shamt    = shamt;
        for (int n = 0; n < 40; n++) begin
            tick();
            ctrl_start = 1'b0;
            lat++;
            if (o_done === 1'b1) break;
        end
        if (o_done !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL run_op timeout: o_done %b expected 1", o_done);
        end
    endtask

    int lat;
    int dc0;

    initial begin
        reset      = 1'b1;
        ctrl_start = 1'b0;
        i_op       = 1'b0;
        i_data     = '0;
        i_shamt    = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("idle ready",  WIDTH'(o_ready), 32'd1);
        chk("idle busy",   WIDTH'(o_busy),  32'd0);
        chk("idle done",   WIDTH'(o_done),  32'd0);
        chk("idle result", o_result,        32'h0);

        // SLL 1 by 4
        run_op(1'b0, 32'h0000_0001, 5'd4, lat);
        chk("sll4 latency", WIDTH'(lat), 32'd5);
        chk("sll4 result",  o_result, 32'h0000_0010);
        tick();
        chk("sll4 ready after done", WIDTH'(o_ready), 32'd1);
        repeat (3) tick();
        chk("sll4 result held", o_result, 32'h0000_0010);

        // SRA boundary cases
        run_op(1'b1, 32'h8000_0000, 5'd31, lat);
        chk("sra31 latency", WIDTH'(lat), 32'd32);
        chk("sra31 result",  o_result, 32'hFFFF_FFFF);
        tick();
        run_op(1'b1, 32'h4000_0000, 5'd30, lat);
        chk("sra30 latency", WIDTH'(lat), 32'd31);
        chk("sra30 result",  o_result, 32'h0000_0001);
        tick();

        // zero shift amount, both ops
        run_op(1'b0, 32'hDEAD_BEEF, 5'd0, lat);
        chk("sll0 latency", WIDTH'(lat), 32'd1);
        chk("sll0 result",  o_result, 32'hDEAD_BEEF);
        tick();
        run_op(1'b1, 32'hDEAD_BEEF, 5'd0, lat);
        chk("sra0 latency", WIDTH'(lat), 32'd1);
        chk("sra0 result",  o_result, 32'hDEAD_BEEF);
        tick();

        // SRA of a positive operand and SLL discarding top bits
        run_op(1'b1, 32'h7000_0000, 5'd4, lat);
        chk("sra pos result", o_result, 32'h0700_0000);
        tick();
        run_op(1'b0, 32'hF000_000F, 5'd4, lat);
        chk("sll drop result", o_result, 32'h0000_00F0);
        tick();

        // start while busy is ignored
        dc0 = done_cnt;
        ctrl_start = 1'b1;
        i_op       = 1'b0;
        i_data     = 32'h0000_00A5;
        i_shamt    = 5'd8;
        tick();
        ctrl_start = 1'b0;
        tick();
        tick();
        ctrl_start = 1'b1;
        i_op       = 1'b1;
        i_data     = 32'h8000_1234;
        i_shamt    = 5'd2;
        tick();
        tick();
        ctrl_start = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        chk("ignore result", o_result, 32'h0000_A500);
        chk("ignore done pulses", WIDTH'(done_cnt - dc0), 32'd1);

        // reset mid-operation
        dc0 = done_cnt;
        ctrl_start = 1'b1;
        i_op       = 1'b0;
        i_data     = 32'h0000_0003;
        i_shamt    = 5'd20;
        tick();
        ctrl_start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst ready",  WIDTH'(o_ready), 32'd1);
        chk("rst result", o_result, 32'h0);
        repeat (15) tick();
        chk("rst no done", WIDTH'(done_cnt - dc0), 32'd0);
        run_op(1'b0, 32'h0000_0001, 5'd1, lat);
        chk("post rst latency", WIDTH'(lat), 32'd2);
        chk("post rst result",  o_result, 32'h0000_0002);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
